// File: rtl/flash_bus_bridge_if.sv
// flash_bus_bridge_if
// Transaction channel between the 6809 flash window bridge and the flash
// controller.
//
// Signals:
//   o_req        one-cycle transaction request (bridge -> controller)
//   o_req_rw     1 = read, 0 = write
//   o_req_addr   12-bit offset inside the 4 KB flash window
//   o_req_data   write data
//   i_done       one-cycle completion (controller -> bridge)
//   i_rdata      read data, valid with i_done
//
// Modports: master = bridge side, slave = flash controller side.
interface flash_bus_bridge_if;
  logic        o_req;
  logic        o_req_rw;
  logic [11:0] o_req_addr;
  logic [7:0]  o_req_data;
  logic        i_done;
  logic [7:0]  i_rdata;

  modport master (
    output o_req, o_req_rw, o_req_addr, o_req_data,
    input  i_done, i_rdata
  );

  modport slave (
    input  o_req, o_req_rw, o_req_addr, o_req_data,
    output i_done, i_rdata
  );
endinterface

// File: rtl/flash_bus_bridge.sv
// flash_bus_bridge
// Bridges 6809 bus cycles that fall into a 4 KB flash window onto a simple
// request/done flash controller channel. The 6809 E clock is synchronized
// into clk; MRDY is pulled low to stretch E until the flash transaction
// completes or times out.
//
// Ports:
//   clk            system clock
//   reset          asynchronous, active-low reset
//   i_E            6809 E clock (asynchronous to clk)
//   i_ADDRESS_BUS  6809 address
//   i_DataBus      6809 write data
//   i_RW           1 = read, 0 = write
//   o_spi_ce       high while a window access is in progress
//   flash          flash controller channel (flash_bus_bridge_if.master)
//   o_DataBus      read data to the 6809
//   o_data_oe      drive enable for o_DataBus
//   o_MemoryReady  6809 MRDY (low stretches E)
//   o_error        sticky timeout flag
//
// Configuration macro:
//   FLASH_READ_CACHE_EN  adds a one-entry read cache; a read hitting the
//                        cached address completes without a flash request.
module flash_bus_bridge #(
  parameter logic [15:0] BASE_ADDR      = 16'hE000,
  parameter int          SETUP_CYCLES   = 2,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_E,
  input  logic [15:0]               i_ADDRESS_BUS,
  input  logic [7:0]                i_DataBus,
  input  logic                      i_RW,
  output logic                      o_spi_ce,
  flash_bus_bridge_if.master        flash,
  output logic [7:0]                o_DataBus,
  output logic                      o_data_oe,
  output logic                      o_MemoryReady,
  output logic                      o_error
);

  localparam int SW = $clog2(SETUP_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, SETUP, REQ, WAIT, HOLD} state_t;

  state_t         r_state;
  state_t         w_nextState;
  logic [1:0]     r_eSync;
  logic           r_eDly;
  logic [SW-1:0]  r_setupCnt;
  logic [TW-1:0]  r_timeoutCnt;
  logic [11:0]    r_reqAddr;
  logic           r_reqRw;
  logic [7:0]     r_reqData;
  logic [7:0]     r_dataBus;
  logic           r_error;

  logic w_eRise;
  logic w_eLow;
  logic w_hit;
  logic w_setupLast;
  logic w_timeout;
  logic w_cacheHit;

  assign w_eRise     = r_eSync[1] & ~r_eDly;
  assign w_eLow      = ~r_eSync[1];
  assign w_hit       = (i_ADDRESS_BUS[15:12] == BASE_ADDR[15:12]);
  assign w_setupLast = (r_setupCnt == SW'(SETUP_CYCLES - 1));
  assign w_timeout   = (r_timeoutCnt == TW'(TIMEOUT_CYCLES));

`ifdef FLASH_READ_CACHE_EN
  logic        r_cacheValid;
  logic [11:0] r_cacheTag;
  logic [7:0]  r_cacheData;

  assign w_cacheHit = r_reqRw && r_cacheValid && (r_cacheTag == r_reqAddr);
`else
  assign w_cacheHit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  // Next-state logic. HOLD leaves on the synchronized E level rather than
  // the fall edge, so a fall that happened during SETUP/REQ/WAIT still lets
  // HOLD exit right away.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_eRise && w_hit) w_nextState = SETUP;
      SETUP:   if (w_setupLast) w_nextState = w_cacheHit ? HOLD : REQ;
      REQ:     w_nextState = flash.i_done ? HOLD : WAIT;
      WAIT:    if (flash.i_done || w_timeout) w_nextState = HOLD;
      HOLD:    if (w_eLow) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Outputs decoded from state plus the latched transaction registers
  always_comb begin
    o_spi_ce         = (r_state != IDLE);
    o_MemoryReady    = !(r_state == SETUP || r_state == REQ || r_state == WAIT);
    o_data_oe        = (r_state == HOLD) && r_reqRw;
    flash.o_req      = (r_state == REQ);
    flash.o_req_rw   = r_reqRw;
    flash.o_req_addr = r_reqAddr;
    flash.o_req_data = r_reqData;
    o_DataBus        = r_dataBus;
    o_error          = r_error;
  end

  // E synchronizer, counters, transaction latches and (optional) cache
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_eSync      <= 2'b00;
      r_eDly       <= 1'b0;
      r_setupCnt   <= '0;
      r_timeoutCnt <= '0;
      r_reqAddr    <= 12'h000;
      r_reqRw      <= 1'b1;
      r_reqData    <= 8'h00;
      r_dataBus    <= 8'h00;
      r_error      <= 1'b0;
`ifdef FLASH_READ_CACHE_EN
      r_cacheValid <= 1'b0;
      r_cacheTag   <= 12'h000;
      r_cacheData  <= 8'h00;
`endif
    end else begin
      r_eSync <= {r_eSync[0], i_E};
      r_eDly  <= r_eSync[1];
      case (r_state)
        IDLE: begin
          if (w_eRise && w_hit) begin
            r_reqAddr  <= i_ADDRESS_BUS[11:0];
            r_reqRw    <= i_RW;
            r_setupCnt <= '0;
          end
        end
        SETUP: begin
          r_setupCnt <= r_setupCnt + 1'b1;
          if (w_setupLast) begin
            if (!r_reqRw) r_reqData <= i_DataBus;
            r_timeoutCnt <= '0;
`ifdef FLASH_READ_CACHE_EN
            if (w_cacheHit) r_dataBus <= r_cacheData;
`endif
          end
        end
        REQ, WAIT: begin
          r_timeoutCnt <= r_timeoutCnt + 1'b1;
          if (flash.i_done) begin
            if (r_reqRw) r_dataBus <= flash.i_rdata;
`ifdef FLASH_READ_CACHE_EN
            if (r_reqRw) begin
              r_cacheValid <= 1'b1;
              r_cacheTag   <= r_reqAddr;
              r_cacheData  <= flash.i_rdata;
            end else if (r_cacheTag == r_reqAddr) begin
              r_cacheData  <= r_reqData;
            end
`endif
          end else if (r_state == WAIT && w_timeout) begin
            r_error <= 1'b1;
            if (r_reqRw) r_dataBus <= 8'hFF;
`ifdef FLASH_READ_CACHE_EN
            r_cacheValid <= 1'b0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/flash_bus_bridge.md
FLASH_BUS_BRIDGE -- requirements
Module: flash_bus_bridge

Interface
REQ-001 Parameters SHALL be: BASE_ADDR, 16'hE000, 4 KB flash window base (low 12 bits zero); SETUP_CYCLES, 2, clk cycles from E-rise detect to request issue; TIMEOUT_CYCLES, 255, maximum clk cycles waited for i_done.
REQ-002 Ports SHALL be: clk  in  1  system clock, single clock domain, all state on posedge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 i_E  in  1  6809 E clock, asynchronous to clk.
REQ-005 i_ADDRESS_BUS  in  16  6809 address; i_DataBus  in  8  6809 write data; i_RW  in  1  1=read, 0=write.
REQ-006 o_spi_ce  out  1  high while a window access is in progress (IDLE excluded).
REQ-007 o_req  out  1  one-cycle transaction request to the flash controller; o_req_rw  out  1; o_req_addr  out  12; o_req_data  out  8.
REQ-008 i_done  in  1  one-cycle completion from flash controller; i_rdata  in  8  read data, valid with i_done.
REQ-009 o_DataBus  out  8  read data to 6809; o_data_oe  out  1  drive enable for o_DataBus.
REQ-010 o_MemoryReady  out  1  6809 MRDY, low stretches E; o_error  out  1  sticky timeout flag.

Function
REQ-011 i_E SHALL pass through a 2-flop synchronizer; rise/fall events are detected on the synchronized signal (detect latency 3 clk from the pin).
REQ-012 An access SHALL be a window hit when i_ADDRESS_BUS[15:12] == BASE_ADDR[15:12], sampled in the rise-detect cycle.
REQ-013 FSM states SHALL be IDLE, SETUP, REQ, WAIT, HOLD.
REQ-014 IDLE: on rise detect with window hit -> SETUP; latch o_req_addr = address[11:0] and o_req_rw = i_RW; o_MemoryReady low from the next cycle; miss -> stay IDLE, no output change.
REQ-015 SETUP: count SETUP_CYCLES cycles; in the last cycle latch o_req_data = i_DataBus (writes only); -> REQ.
REQ-016 REQ: o_req high exactly one cycle; -> WAIT; an i_done in this same cycle SHALL be accepted as completion (-> HOLD).
REQ-017 WAIT: on i_done latch i_rdata into o_DataBus for reads -> HOLD; timeout counter is cleared on entry to REQ and increments each cycle; when it reaches TIMEOUT_CYCLES -> HOLD, set o_error, o_DataBus = 8'hFF for reads.
REQ-018 HOLD: o_MemoryReady high; o_data_oe high only for reads; on synchronized E fall -> IDLE with o_data_oe low the following cycle.
REQ-019 A synchronized E fall occurring in SETUP/REQ/WAIT SHALL be ignored; the transaction completes normally and HOLD exits on the next E fall (or immediately if E is already low).
REQ-020 A new E rise SHALL be recognized only in IDLE; i_done outside REQ/WAIT SHALL be ignored.
REQ-021 o_error SHALL remain set until reset.

Reset
REQ-022 On reset low, asynchronously: state IDLE, o_MemoryReady=1, o_req=0, o_spi_ce=0, o_data_oe=0, o_DataBus=0, o_req_rw=1, o_req_addr=0, o_req_data=0, o_error=0, counters 0, synchronizer flops 0.
REQ-023 Reset mid-transaction SHALL abandon it with no further o_req pulse; the first access after release requires a fresh E rise.

Configuration
REQ-024 Macro FLASH_READ_CACHE_EN defined: a one-entry read cache (valid, 12-bit tag, 8-bit data) SHALL exist; a read hitting a valid tag goes SETUP -> HOLD after SETUP_CYCLES with cached data and no o_req; a completed read fills the entry; a completed write to the tagged address updates the cached data; a timeout invalidates; reset invalidates.
REQ-025 Macro undefined: no cache logic; every window access issues o_req.

Verification
REQ-026 Read 0xE123, flash returns 8'h5A after 10 cycles -> o_req once with addr 12'h123, rw=1; MRDY low until i_done; o_DataBus=8'h5A with oe until E falls.
REQ-027 Write 8'hC3 to 0xEFFF -> o_req with rw=0, addr 12'hFFF, data 8'hC3; o_data_oe never high.
REQ-028 Read 0x8000 -> no o_req, o_spi_ce and MRDY unchanged.
REQ-029 Read 0xE010, i_done never asserted -> MRDY released after 255 WAIT cycles, o_DataBus=8'hFF, o_error=1 and sticky.
REQ-030 i_done in the REQ cycle -> completion accepted; reset asserted in WAIT -> all outputs at reset values immediately, no further o_req.
REQ-031 With FLASH_READ_CACHE_EN: two reads of 0xE200 -> one o_req only, second returns the same data; write 8'h11 to 0xE200 then read -> 8'h11, no read o_req.
